serial_addsub_nbit: RTL and testbench
=====================================

// Module: serial_addsub_nbit
// PURPOSE
//  Bit-serial N-bit adder/subtractor: the sequential counterpart of the combinational ripple-carry
//  adder. Computes A+B or A-B one bit per clock through a single mux-based full-adder cell.
//  Operands are captured on a start/done handshake. Trades N cycles of latency for one FA cell.
//  Used as an area-minimal datapath unit.
// PARAMETERS
//  N   4   operand/result width in bits (N >= 2)
// PORTS
//  clk      in   1  rising-edge clock
//  rst_n    in   1  asynchronous, active-low reset
//  start    in   1  request; accepted only when busy==0
//  sub      in   1  0: A+B, 1: A-B (two's complement); sampled with start
//  a        in   N  operand A (signed); sampled with start
//  b        in   N  operand B (signed); sampled with start
//  busy     out  1  operation in progress
//  done     out  1  one-cycle pulse: result/cout valid
//  result   out  N  sum/difference, registered
//  cout     out  1  final carry; for sub, 1 = no borrow
//  ovf      out  1  signed overflow (only with SERIAL_OVF_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; internal regs cleared.
//  - FSM: IDLE -> SHIFT on accepted start; SHIFT -> DONE when bit counter reaches N-1; DONE -> IDLE
//    after one cycle, or DONE -> SHIFT if start is asserted in DONE.
//  - Accept (edge E0, busy==0 && start): opA<=a; opB<=sub ? ~b : b; carry<=sub; cnt<=0.
//    After E0 busy=1.
//  - SHIFT edge k (k=1..N): FA(opA[0], opB[0], carry) -> s,c. acc<={s, acc[N-1:1]}.
//    opA/opB shift right. carry<=c. cnt++. The carry into the MSB is saved on the Nth bit (for ovf).
//  - After edge EN: state=DONE, busy=0, done=1 for exactly one cycle.
//    result<=final acc, cout<=final carry. Latency start->done = N+1 edges.
//  - result/cout/ovf update only at completion and hold until the next completion; stable while busy.
//  - start while busy: ignored, no effect on the operation in flight.
//  - start in the DONE cycle: accepted (busy==0). done pulses and the new operation begins on that edge.
//  - Width rules: result is modulo 2^N. cout is the carry out of bit N-1. a/b changes after accept are ignored.
//  - Reset mid-operation: aborts immediately, all outputs return to reset values, no done pulse.
// CONFIGURATION
//  - SERIAL_OVF_EN defined: output ovf present. ovf = carry_into_msb XOR carry_out.
//    It is registered with result and holds like result.
//  - SERIAL_OVF_EN undefined: no ovf port and no carry_into_msb register; all other behaviour identical.
// STRUCTURE
//  - Package serial_addsub_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t.
//    Also holds the counter width function/constant CNT_W = $clog2(N).
//  - One sub-module: full_adder_mux (1-bit a, b, cin -> sum, cout; mux-based).
//    It is instantiated once for the serial cell.
//  - Top holds FSM, counter, operand/accumulator shift registers, output registers.
// TESTING (N=4; each op: pulse start one cycle, wait for done)
//  - Reset: rst_n=0 asynchronously, mid-cycle -> busy=0, done=0, result=0, cout=0 immediately.
//  - add 3+5 -> done at edge 5 after accept; result=4'b1000 (-8), cout=0, ovf=1.
//  - sub 7-2 -> result=4'd5, cout=1, ovf=0. sub 2-7 -> result=4'b1011 (-5), cout=0, ovf=0.
//  - sub -8-1 -> result=4'b0111, cout=1, ovf=1. add -1+-1 -> result=4'b1110, cout=1, ovf=0.
//  - start pulsed with 1+1 while busy with 2+3 -> ignored; result=5, single done pulse.
//  - back-to-back: start held in DONE cycle with 4+1 -> prior result kept until the second done.
//    Second result=5.
//  - rst_n low at SHIFT edge 2 of 6+1 -> no done; outputs at reset values.
//    Next 1+2 after release -> result=3.
//  - Exhaustive: a,b in -8..7, sub in {0,1} vs golden a±b mod 16 and carry/overflow model.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM state type and counter-width helper for the bit-serial adder/subtractor
package serial_addsub_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_nbit_fa.sv
// full_adder_mux: one-bit full adder whose sum and carry are both selected by the propagate term
module full_adder_mux (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ? ~cin : cin;
    assign cout = p ? cin : a;

endmodule

// File: rtl/serial_addsub_nbit.sv
// serial_addsub_nbit: bit-serial N-bit add/sub through one full-adder cell; define SERIAL_OVF_EN for the ovf output
module serial_addsub_nbit
    import serial_addsub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout
`ifdef SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = cnt_w(N);

    state_t        state, state_nx;
    logic [N-1:0]  opa, opb, acc_nx;
    logic [N-2:0]  acc;
    logic [CW-1:0] cnt;
    logic          carry, fa_s, fa_c, accept, last;

    assign accept = start && (state != SHIFT);
    assign last   = (state == SHIFT) && (cnt == CW'(N - 1));
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign acc_nx = {fa_s, acc};

    full_adder_mux u_fa (
        .a   (opa[0]),
        .b   (opb[0]),
        .cin (carry),
        .sum (fa_s),
        .cout(fa_c)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: a start outside SHIFT always wins, so DONE can chain straight into a new operation
    always_comb begin
        state_nx = state;
        state_nx = accept ? SHIFT : last ? DONE : (state == DONE) ? IDLE : state;
    end

    // operand capture, one bit per cycle through the cell, and result registers loaded on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                opa   <= a;
                opb   <= sub ? ~b : b;
                carry <= sub;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                acc   <= acc_nx[N-1:1];
                opa   <= opa >> 1;
                opb   <= opb >> 1;
                carry <= fa_c;
                cnt   <= cnt + 1'b1;
            end
            if (last) begin
                result <= acc_nx;
                cout   <= fa_c;
`ifdef SERIAL_OVF_EN
                ovf    <= carry ^ fa_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_nbit.sv
// tb_serial_addsub_nbit: scoreboard bench for the 4-bit serial adder/subtractor
module tb_serial_addsub_nbit;

    typedef struct {
        logic [3:0] r;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy, done, cout;
    logic [3:0] result;
`ifdef SERIAL_OVF_EN
    logic       ovf;
`endif

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    exp_t q[$];

    serial_addsub_nbit #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result),
        .cout  (cout)
`ifdef SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic s);
        logic [4:0] f;
        exp_t e;
        f = s ? ({1'b0, x} + {1'b0, ~y} + 5'd1) : ({1'b0, x} + {1'b0, y});
        e.r = f[3:0];
        e.c = f[4];
        e.o = s ? ((x[3] != y[3]) && (f[3] != x[3])) : ((x[3] == y[3]) && (f[3] != x[3]));
        return e;
    endfunction

    // monitor: every done pulse pops one expected response
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", {4'd0, result}, {4'd0, e.r});
                chk("cout", {7'd0, cout}, {7'd0, e.c});
`ifdef SERIAL_OVF_EN
                chk("ovf", {7'd0, ovf}, {7'd0, e.o});
`endif
            end
        end
    end

    task automatic push(input logic [3:0] r, input logic c, input logic o);
        exp_t e;
        e.r = r;
        e.c = c;
        e.o = o;
        q.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] x, input logic [3:0] y, input logic s);
        @(negedge clk);
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (i == 20) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
        end
    endtask

    task automatic op(input logic [3:0] x, input logic [3:0] y, input logic s,
                      input logic [3:0] r, input logic c, input logic o);
        push(r, c, o);
        pulse(x, y, s);
        wait_done("op");
        @(negedge clk);
    endtask

    initial begin
        int d0;
        exp_t e;
        #12;
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);
        chk("reset_result", {4'd0, result}, 8'd0);
        rst_n = 1'b1;

        op(4'd3, 4'd5, 1'b0, 4'b1000, 1'b0, 1'b1);
        op(4'd7, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);
        op(4'd2, 4'd7, 1'b1, 4'b1011, 1'b0, 1'b0);
        op(4'b1000, 4'd1, 1'b1, 4'b0111, 1'b1, 1'b1);
        op(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0);

        // asynchronous reset mid-cycle clears outputs immediately
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_busy", {7'd0, busy}, 8'd0);
        chk("async_result", {4'd0, result}, 8'd0);
        chk("async_cout", {7'd0, cout}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // start while busy is ignored
        d0 = done_cnt;
        push(4'd5, 1'b0, 1'b0);
        pulse(4'd2, 4'd3, 1'b0);
        pulse(4'd1, 4'd1, 1'b0);
        wait_done("ignored");
        repeat (8) @(negedge clk);
        chk("single_done", done_cnt[7:0] - d0[7:0], 8'd1);

        // back-to-back: start held in the DONE cycle
        push(4'd4, 1'b0, 1'b0);
        pulse(4'd2, 4'd2, 1'b0);
        wait_done("b2b_first");
        a = 4'd4;
        b = 4'd1;
        sub = 1'b0;
        start = 1'b1;
        push(4'd5, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {7'd0, busy}, 8'd1);
        chk("b2b_hold", {4'd0, result}, 8'd4);
        wait_done("b2b_second");
        @(negedge clk);

        // reset at shift edge 2 aborts with no done
        d0 = done_cnt;
        @(negedge clk);
        a = 4'd6;
        b = 4'd1;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_result", {4'd0, result}, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt[7:0] - d0[7:0], 8'd0);
        op(4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);

        // exhaustive sweep against the arithmetic model
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    e = model(4'(x), 4'(y), 1'(s));
                    op(4'(x), 4'(y), 1'(s), e.r, e.c, e.o);
                end

        repeat (3) @(negedge clk);
        chk("queue_empty", 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
